// File: rtl/fft_reorder_pkg.sv
// Shared definitions for the FFT output reorder block: lane map, bit reversal
// and read-side state encoding.
package fft_reorder_pkg;

    localparam int LANES = 4;

    localparam int LANE_IN0_UP   = 0;
    localparam int LANE_IN0_DOWN = 1;
    localparam int LANE_IN1_UP   = 2;
    localparam int LANE_IN1_DOWN = 3;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_BUSY = 1'b1
    } rd_state_e;

    // Reverses the low nbits of a; bits above nbits come back as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] a, input int nbits);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < nbits) begin
                r[nbits-1-i] = a[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_out_reorder_page_mem.sv
// One N-entry flop page: 4-wide aligned write of beat wr_beat, and four
// independent combinational read ports.
module reorder_page_mem
    import fft_reorder_pkg::*;
#(
    parameter int W     = 30,
    parameter int N     = 128,
    parameter int LOG2N = 7
) (
    input  logic                            clk,
    input  logic                            wr_en,
    input  logic [LOG2N-3:0]                wr_beat,
    input  logic [LANES-1:0][W-1:0]         wr_data,
    input  logic [LANES-1:0][LOG2N-1:0]     rd_addr,
    output logic [LANES-1:0][W-1:0]         rd_data
);

    logic [W-1:0] mem_q [N];
    logic [W-1:0] mem_d [N];

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            for (int l = 0; l < LANES; l++) begin
                mem_d[{wr_beat, 2'(l)}] = wr_data[l];
            end
        end
    end

    // Contents are don't-care after reset, so the page carries no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    for (genvar j = 0; j < LANES; j++) begin : g_rd
        assign rd_data[j] = mem_q[rd_addr[j]];
    end

endmodule

// File: rtl/fft_out_reorder.sv
// Collects bit-reversed FFT frames into a ping-pong buffer and replays each
// frame in natural bin order, four bins per cycle.
//
// state  | meaning
// R_IDLE | no completed page pending; outputs hold, o_valid low
// R_BUSY | replaying page rp_q, beat rd_cnt_q (bins 4r..4r+3)
module fft_out_reorder
    import fft_reorder_pkg::*;
#(
    parameter int NBITS_OUT = 15,
    parameter int N         = 128,
    parameter int LOG2N     = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_enable,
    input  logic [2*NBITS_OUT-1:0]  fftIn0_up,
    input  logic [2*NBITS_OUT-1:0]  fftIn0_down,
    input  logic [2*NBITS_OUT-1:0]  fftIn1_up,
    input  logic [2*NBITS_OUT-1:0]  fftIn1_down,
    output logic                    o_valid,
    output logic                    o_frame_start,
    output logic [2*NBITS_OUT-1:0]  binOut0,
    output logic [2*NBITS_OUT-1:0]  binOut1,
    output logic [2*NBITS_OUT-1:0]  binOut2,
    output logic [2*NBITS_OUT-1:0]  binOut3
);

    localparam int W     = 2 * NBITS_OUT;
    localparam int BEATS = N / 4;
    localparam int CW    = LOG2N - 2;

    logic [CW-1:0]              wr_cnt_q, wr_cnt_d;
    logic                       wp_q, wp_d;
    rd_state_e                  rd_state_q, rd_state_d;
    logic                       rp_q, rp_d;
    logic [CW-1:0]              rd_cnt_q, rd_cnt_d;
    logic                       valid_q, valid_d;
    logic                       fs_q, fs_d;
    logic [LANES-1:0][W-1:0]    bin_q, bin_d;

    logic                       page_full;
    logic [LANES-1:0][W-1:0]    wr_data;
    logic [LANES-1:0][LOG2N-1:0] rd_addr;
    logic [LANES-1:0][W-1:0]    rd_data0, rd_data1, rd_data;

    always_comb begin
        wr_data                = '0;
        wr_data[LANE_IN0_UP]   = fftIn0_up;
        wr_data[LANE_IN0_DOWN] = fftIn0_down;
        wr_data[LANE_IN1_UP]   = fftIn1_up;
        wr_data[LANE_IN1_DOWN] = fftIn1_down;
    end

    assign page_full = i_enable && (wr_cnt_q == CW'(BEATS - 1));

    // Natural bin 4r+j lives at arrival slot bitrev(4r+j).
    for (genvar j = 0; j < LANES; j++) begin : g_addr
        assign rd_addr[j] = LOG2N'(bitrev(32'({rd_cnt_q, 2'(j)}), LOG2N));
    end

    reorder_page_mem #(.W(W), .N(N), .LOG2N(LOG2N)) u_page0 (
        .clk     (clk),
        .wr_en   (i_enable && !wp_q),
        .wr_beat (wr_cnt_q),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data0)
    );

    reorder_page_mem #(.W(W), .N(N), .LOG2N(LOG2N)) u_page1 (
        .clk     (clk),
        .wr_en   (i_enable && wp_q),
        .wr_beat (wr_cnt_q),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data1)
    );

    assign rd_data = rp_q ? rd_data1 : rd_data0;

    always_comb begin
        wr_cnt_d   = wr_cnt_q;
        wp_d       = wp_q;
        rd_state_d = rd_state_q;
        rp_d       = rp_q;
        rd_cnt_d   = rd_cnt_q;
        valid_d    = 1'b0;
        fs_d       = 1'b0;
        bin_d      = bin_q;

        if (i_enable) begin
            wr_cnt_d = wr_cnt_q + CW'(1);
            if (page_full) begin
                wp_d = ~wp_q;
            end
        end

        // The page completing this cycle is wp_q, the one being written.
        case (rd_state_q)
            R_IDLE: begin
                if (page_full) begin
                    rd_state_d = R_BUSY;
                    rp_d       = wp_q;
                    rd_cnt_d   = '0;
                end
            end
            R_BUSY: begin
                valid_d = 1'b1;
                fs_d    = (rd_cnt_q == '0);
                bin_d   = rd_data;
                if (rd_cnt_q == CW'(BEATS - 1)) begin
                    if (page_full) begin
                        rp_d     = wp_q;
                        rd_cnt_d = '0;
                    end else begin
                        rd_state_d = R_IDLE;
                    end
                end else begin
                    rd_cnt_d = rd_cnt_q + CW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_q   <= '0;
            wp_q       <= 1'b0;
            rd_state_q <= R_IDLE;
            rp_q       <= 1'b0;
            rd_cnt_q   <= '0;
            valid_q    <= 1'b0;
            fs_q       <= 1'b0;
            bin_q      <= '0;
        end else begin
            wr_cnt_q   <= wr_cnt_d;
            wp_q       <= wp_d;
            rd_state_q <= rd_state_d;
            rp_q       <= rp_d;
            rd_cnt_q   <= rd_cnt_d;
            valid_q    <= valid_d;
            fs_q       <= fs_d;
            bin_q      <= bin_d;
        end
    end

    assign o_valid       = valid_q;
    assign o_frame_start = fs_q;
    assign binOut0       = bin_q[0];
    assign binOut1       = bin_q[1];
    assign binOut2       = bin_q[2];
    assign binOut3       = bin_q[3];

endmodule

// File: tb/tb_fft_out_reorder.sv
// Directed bench for fft_out_reorder: N=128 instance for the main scenarios
// and an N=16 instance for the small-frame case.
module tb_fft_out_reorder;

    localparam int W      = 15;
    localparam int N      = 128;
    localparam int LOG2N  = 7;
    localparam int BEATS  = N / 4;
    localparam int N2     = 16;
    localparam int LOG2N2 = 4;
    localparam int BEATS2 = N2 / 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            en, en2;
    logic [2*W-1:0]  in0u, in0d, in1u, in1d;
    logic [2*W-1:0]  s0u, s0d, s1u, s1d;
    logic            o_valid, o_fs, v2, fs2;
    logic [2*W-1:0]  b0, b1, b2, b3, c0, c1, c2, c3;

    fft_out_reorder #(.NBITS_OUT(W), .N(N), .LOG2N(LOG2N)) dut (
        .clk(clk), .rst(rst), .i_enable(en),
        .fftIn0_up(in0u), .fftIn0_down(in0d), .fftIn1_up(in1u), .fftIn1_down(in1d),
        .o_valid(o_valid), .o_frame_start(o_fs),
        .binOut0(b0), .binOut1(b1), .binOut2(b2), .binOut3(b3)
    );

    fft_out_reorder #(.NBITS_OUT(W), .N(N2), .LOG2N(LOG2N2)) dut16 (
        .clk(clk), .rst(rst), .i_enable(en2),
        .fftIn0_up(s0u), .fftIn0_down(s0d), .fftIn1_up(s1u), .fftIn1_down(s1d),
        .o_valid(v2), .o_frame_start(fs2),
        .binOut0(c0), .binOut1(c1), .binOut2(c2), .binOut3(c3)
    );

    typedef struct {
        int             cyc;
        logic           fs;
        logic [2*W-1:0] b [4];
    } rec_t;

    rec_t q[$];
    rec_t q2[$];
    int   cyc_pos = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk) cyc_pos++;

    always @(negedge clk) begin : mon
        rec_t r;
        if (o_valid === 1'b1) begin
            r.cyc = cyc_pos; r.fs = o_fs;
            r.b[0] = b0; r.b[1] = b1; r.b[2] = b2; r.b[3] = b3;
            q.push_back(r);
        end
        if (v2 === 1'b1) begin
            r.cyc = cyc_pos; r.fs = fs2;
            r.b[0] = c0; r.b[1] = c1; r.b[2] = c2; r.b[3] = c3;
            q2.push_back(r);
        end
    end

    function automatic int rev(input int k, input int nb);
        int r = 0;
        for (int i = 0; i < nb; i++) if (k[i]) r |= (1 << (nb - 1 - i));
        return r;
    endfunction

    function automatic logic [2*W-1:0] cval(input int v);
        return {W'(v), W'(-v)};
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input int off, input bit gap, input int nbeats, output int last);
        last = 0;
        for (int c = 0; c < nbeats; c++) begin
            @(negedge clk);
            in0u = cval(4*c + 0 + off);
            in0d = cval(4*c + 1 + off);
            in1u = cval(4*c + 2 + off);
            in1d = cval(4*c + 3 + off);
            en   = 1'b1;
            last = cyc_pos;
            if (gap && c != nbeats - 1) begin
                @(negedge clk);
                en = 1'b0;
            end
        end
    endtask

    task automatic check_frame(input int base, input int off, input int first, input string tag);
        for (int r = 0; r < BEATS; r++) begin
            chk($sformatf("%s_present_r%0d", tag, r), longint'(q.size() > base + r), 1);
            if (q.size() > base + r) begin
                chk($sformatf("%s_cyc_r%0d", tag, r), q[base+r].cyc, first + r);
                chk($sformatf("%s_fs_r%0d", tag, r), q[base+r].fs, (r == 0) ? 1 : 0);
                for (int j = 0; j < 4; j++) begin
                    chk($sformatf("%s_bin_r%0d_j%0d", tag, r, j), q[base+r].b[j],
                        cval(rev(4*r + j, LOG2N) + off));
                end
            end
        end
    endtask

    int last;
    int lastf [4];
    int last2;

    initial begin
        rst = 1'b1; en = 1'b1; en2 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in0u = 30'($urandom); in0d = 30'($urandom); in1u = 30'($urandom); in1d = 30'($urandom);
            s0u = 30'($urandom); s0d = 30'($urandom); s1u = 30'($urandom); s1d = 30'($urandom);
            @(negedge clk);
        end
        chk("rst_valid", o_valid, 0);
        chk("rst_fs", o_fs, 0);
        chk("rst_b0", b0, 0);
        chk("rst_b1", b1, 0);
        chk("rst_b2", b2, 0);
        chk("rst_b3", b3, 0);
        chk("rst_valid16", v2, 0);
        rst = 1'b0; en = 1'b0; en2 = 1'b0;
        q.delete(); q2.delete();

        // single frame, real = a, imag = -a
        send_frame(0, 1'b0, BEATS, last);
        @(negedge clk); en = 1'b0;
        repeat (BEATS + 4) @(negedge clk);
        chk("single_count", q.size(), BEATS);
        if (q.size() >= 2) begin
            chk("single_b0_re0", q[0].b[0][2*W-1:W], 0);
            chk("single_b0_re1", q[0].b[1][2*W-1:W], 64);
            chk("single_b0_re2", q[0].b[2][2*W-1:W], 32);
            chk("single_b0_re3", q[0].b[3][2*W-1:W], 96);
            chk("single_b1_re0", q[1].b[0][2*W-1:W], 16);
            chk("single_b1_re1", q[1].b[1][2*W-1:W], 80);
            chk("single_b1_re2", q[1].b[2][2*W-1:W], 48);
            chk("single_b1_re3", q[1].b[3][2*W-1:W], 112);
        end
        check_frame(0, 0, last + 2, "single");
        q.delete();

        // three frames back to back
        for (int f = 1; f <= 3; f++) send_frame(f * 1000, 1'b0, BEATS, lastf[f]);
        @(negedge clk); en = 1'b0;
        repeat (BEATS + 4) @(negedge clk);
        chk("b2b_count", q.size(), 3 * BEATS);
        for (int f = 1; f <= 3; f++)
            check_frame((f - 1) * BEATS, f * 1000, lastf[1] + 2 + (f - 1) * BEATS, $sformatf("b2b_f%0d", f));
        q.delete();

        // gapped input, one beat every other cycle
        send_frame(0, 1'b1, BEATS, last);
        @(negedge clk); en = 1'b0;
        repeat (BEATS + 4) @(negedge clk);
        chk("gap_count", q.size(), BEATS);
        check_frame(0, 0, last + 2, "gap");
        q.delete();

        // reset after 10 write beats, then a clean frame
        send_frame(7000, 1'b0, 10, last);
        @(negedge clk); en = 1'b0; rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        send_frame(5000, 1'b0, BEATS, last);
        @(negedge clk); en = 1'b0;
        repeat (BEATS + 4) @(negedge clk);
        chk("wrst_count", q.size(), BEATS);
        check_frame(0, 5000, last + 2, "wrst");
        q.delete();

        // reset during read beat 5
        send_frame(6000, 1'b0, BEATS, last);
        @(negedge clk); en = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("rrst_valid", o_valid, 0);
        chk("rrst_fs", o_fs, 0);
        chk("rrst_b0", b0, 0);
        repeat (BEATS + 4) @(negedge clk);
        chk("rrst_count", q.size(), 6);
        if (q.size() >= 6) chk("rrst_last_cyc", q[5].cyc, last + 7);
        q.delete();

        // N=16 instance
        for (int c = 0; c < BEATS2; c++) begin
            @(negedge clk);
            s0u = cval(4*c); s0d = cval(4*c + 1); s1u = cval(4*c + 2); s1d = cval(4*c + 3);
            en2 = 1'b1;
            last2 = cyc_pos;
        end
        @(negedge clk); en2 = 1'b0;
        repeat (BEATS2 + 4) @(negedge clk);
        chk("n16_count", q2.size(), BEATS2);
        if (q2.size() >= 2) begin
            chk("n16_cyc0", q2[0].cyc, last2 + 2);
            chk("n16_fs0", q2[0].fs, 1);
            chk("n16_fs1", q2[1].fs, 0);
            chk("n16_b0_0", q2[0].b[0], cval(0));
            chk("n16_b0_1", q2[0].b[1], cval(8));
            chk("n16_b0_2", q2[0].b[2], cval(4));
            chk("n16_b0_3", q2[0].b[3], cval(12));
            chk("n16_b1_0", q2[1].b[0], cval(2));
            chk("n16_b1_1", q2[1].b[1], cval(10));
            chk("n16_b1_2", q2[1].b[2], cval(6));
            chk("n16_b1_3", q2[1].b[3], cval(14));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
